fir_out_requant: RTL and testbench

Downstream stage of the 5-tap FIR filter: consumes the filter's 16-bit signed output stream, decimates it by a fixed ratio, requantizes each kept sample to a narrower signed word (round-half-up, saturate), and buffers results in a small first-word-fall-through FIFO behind a valid/ready output handshake. It decouples the free-running filter from slower or stalling sinks (DAC serializer, packetizer) and reports overflow and saturation events through sticky flags.

---
 rtl/fir_out_requant.sv | 122 ++++++++++++
 tb/tb_fir_out_requant.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_out_requant.sv
// fir_out_requant: decimates the FIR output stream, requantizes kept samples
// (round-half-up, arithmetic shift, saturate) and buffers them in a small
// first-word-fall-through FIFO behind a valid/ready handshake.
module fir_out_requant #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4,
  parameter int DECIM = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [IN_W-1:0]     in_sample,
  input  logic                       in_valid,
  output logic signed [OUT_W-1:0]    out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic                       sat_hit,
  input  logic                       clear_flags
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(DECIM-1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  // Requantize constants live at IN_W+1 bits so the rounding add cannot wrap.
  localparam logic signed [IN_W:0] RND  =
    (SHIFT > 0) ? (IN_W+1)'(1 << ((SHIFT > 0) ? SHIFT-1 : 0)) : '0;
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W:0] MINV = -(IN_W+1)'(1 << (OUT_W-1));

  typedef struct packed {
    logic                    vld;
    logic signed [OUT_W-1:0] data;
  } stg_t;

  logic [PW-1:0]           phase;
  logic                    keep;
  logic signed [IN_W:0]    wide, rnd, shifted;
  logic                    clip;
  logic signed [OUT_W-1:0] q;
  stg_t                    stg;

  logic signed [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]           wptr, rptr;
  logic                    full, rd, wr_ok, wr_drop;

  assign keep = in_valid && (phase == '0);

  // Round-half-up, floor shift, clamp to the OUT_W signed range.
  always_comb begin
    wide    = {in_sample[IN_W-1], in_sample};
    rnd     = wide + RND;
    shifted = rnd >>> SHIFT;
    clip    = 1'b0;
    q       = shifted[OUT_W-1:0];
    if (shifted > MAXV) begin
      clip = 1'b1;
      q    = MAXV[OUT_W-1:0];
    end else if (shifted < MINV) begin
      clip = 1'b1;
      q    = MINV[OUT_W-1:0];
    end
  end

  // Phase counter advances only on valid inputs; stage register captures kept samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      stg   <= '0;
    end else begin
      if (in_valid) phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      stg.vld  <= keep;
      stg.data <= keep ? q : stg.data;
    end
  end

  assign full      = (level == LVL_FULL);
  assign out_valid = (level != '0);
  assign rd        = out_valid && out_ready;
  // A read in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_ok     = stg.vld && (!full || rd);
  assign wr_drop   = stg.vld && full && !rd;
  assign out_data  = out_valid ? mem[rptr] : '0;

  // Storage array: written only, never reset (contents gated by level).
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= stg.data;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd)    rptr <= rptr + 1'b1;
      case ({wr_ok, rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky flags; a new set event beats a coincident clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      sat_hit  <= 1'b0;
    end else begin
      if (wr_drop)          overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
      if (keep && clip)     sat_hit  <= 1'b1;
      else if (clear_flags) sat_hit  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fir_out_requant.sv
// tb_fir_out_requant: directed vectors with hand-computed expectations for
// decimation, rounding, saturation, FIFO full/drain and async reset.
module tb_fir_out_requant;
  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] in_sample = '0;
  logic               in_valid = 1'b0;
  logic signed [7:0]  out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [3:0]         level;
  logic               overflow;
  logic               sat_hit;
  logic               clear_flags = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int got[$];

  fir_out_requant dut (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .sat_hit(sat_hit),
    .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  // Record every word the sink accepts (handshake completes on the next rising edge).
  always @(negedge clk)
    if (!reset && out_valid && out_ready) got.push_back(int'(out_data));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int v, input logic vld);
    in_sample = 16'(v);
    in_valid  = vld;
  endtask

  // One kept sample followed by DECIM-1 discarded valid samples.
  task automatic feed(input int v);
    drive(v, 1'b1); step();
    repeat (3) begin drive(0, 1'b1); step(); end
  endtask

  task automatic do_reset();
    drive(0, 1'b0);
    out_ready = 1'b0;
    clear_flags = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    got.delete();
  endtask

  task automatic chk_q(input string tag, input int exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", tag, i), got[i], exp[i]);
  endtask

  task automatic drain(input string tag);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 40) begin step(); n++; end
    chk({tag, "_drained"}, int'(out_valid), 0);
    chk({tag, "_level0"}, int'(level), 0);
  endtask

  initial begin
    int exp[$];

    // Reset state
    step(); step();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_sat", int'(sat_hit), 0);

    // Decimation with continuous valid, including first-output latency
    do_reset();
    out_ready = 1'b1;
    drive(16, 1'b1); step();
    chk("lat_n1_valid", int'(out_valid), 0);
    drive(32, 1'b1); step();
    chk("lat_n2_valid", int'(out_valid), 1);
    chk("lat_n2_data", int'(out_data), 1);
    for (int k = 3; k <= 10; k++) begin drive(16*k, 1'b1); step(); end
    drive(0, 1'b0);
    repeat (4) step();
    exp = '{1, 5, 9};
    chk_q("decim", exp);

    // Same stream with idle gaps carrying would-be-clipping garbage
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      drive(16*k, 1'b1); step();
      drive(5000, 1'b0); step();
    end
    drive(0, 1'b0);
    repeat (4) step();
    chk_q("gaps", exp);
    chk("gaps_sat", int'(sat_hit), 0);

    // Rounding
    do_reset();
    out_ready = 1'b1;
    feed(24); feed(23); feed(-24); feed(-25);
    drive(0, 1'b0);
    repeat (3) step();
    exp = '{2, 1, -1, -2};
    chk_q("round", exp);
    chk("round_sat", int'(sat_hit), 0);

    // Saturation, clear, and clear coincident with a new clip
    got.delete();
    feed(4000); feed(-4000);
    chk("sat_set", int'(sat_hit), 1);
    drive(0, 1'b0);
    clear_flags = 1'b1; step();
    clear_flags = 1'b0;
    chk("sat_clear", int'(sat_hit), 0);
    drive(4000, 1'b1);
    clear_flags = 1'b1; step();
    clear_flags = 1'b0;
    chk("sat_set_wins", int'(sat_hit), 1);
    repeat (3) begin drive(0, 1'b1); step(); end
    drive(0, 1'b0);
    repeat (3) step();
    exp = '{127, -128, 127};
    chk_q("sat", exp);
    chk("sat_no_ovf", int'(overflow), 0);

    // FIFO full: ninth sample dropped
    do_reset();
    for (int k = 1; k <= 9; k++) feed(16*k);
    drive(0, 1'b0);
    step();
    chk("full_level", int'(level), 8);
    chk("full_ovf", int'(overflow), 1);
    chk("full_head", int'(out_data), 1);
    drain("full");
    exp = '{1, 2, 3, 4, 5, 6, 7, 8};
    chk_q("full", exp);
    chk("full_ovf_sticky", int'(overflow), 1);

    // Full with simultaneous read and write
    do_reset();
    for (int k = 1; k <= 8; k++) feed(16*k);
    chk("rw_pre_level", int'(level), 8);
    drive(144, 1'b1); step();
    drive(0, 1'b0);
    out_ready = 1'b1; step();
    out_ready = 1'b0;
    chk("rw_level", int'(level), 8);
    chk("rw_ovf", int'(overflow), 0);
    drain("rw");
    exp = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    chk_q("rw", exp);

    // Asynchronous reset mid-stream with stage register holding a clipped sample
    do_reset();
    for (int k = 1; k <= 5; k++) feed(16*k);
    drive(4000, 1'b1); step();
    drive(0, 1'b0);
    chk("mid_level", int'(level), 5);
    chk("mid_sat", int'(sat_hit), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", int'(out_valid), 0);
    chk("async_level", int'(level), 0);
    chk("async_sat", int'(sat_hit), 0);
    chk("async_ovf", int'(overflow), 0);
    step();
    reset = 1'b0;
    got.delete();
    step();
    drive(32, 1'b1); step();
    drive(0, 1'b0);
    out_ready = 1'b1;
    repeat (4) step();
    exp = '{2};
    chk_q("post_rst", exp);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
